// File: rtl/input_trigger_mc_if.sv
// Trigger front-end bundle: raw trigger inputs and controls toward the sequencer,
// increment/refresh pulses and status back out. dbg_* expose FSM state and pending mask.
interface input_trigger_mc_if #(
  parameter int CHANNELS = 6
);
  // Pulse semantics: inc_clk and ref_clk are single-cycle strobes with no back-pressure;
  // inc_mask is meaningful only while inc_clk=1 and reads 0 otherwise.
  logic [CHANNELS-1:0] trigger;
  logic [1:0]          edge_mode;
  logic                enable;
  logic                overrun_clr;
  logic                inc_clk;
  logic [CHANNELS-1:0] inc_mask;
  logic                ref_clk;
  logic                busy;
  logic                overrun;
  logic [1:0]          dbg_state;
  logic [CHANNELS-1:0] dbg_pending;

  modport slave (
    input  trigger, edge_mode, enable, overrun_clr,
    output inc_clk, inc_mask, ref_clk, busy, overrun, dbg_state, dbg_pending
  );

  modport master (
    output trigger, edge_mode, enable, overrun_clr,
    input  inc_clk, inc_mask, ref_clk, busy, overrun, dbg_state, dbg_pending
  );
endinterface

// File: rtl/input_trigger_mc.sv
// Multi-channel debounce and trigger sequencer: per-channel sync + stable-time filter,
// qualified edges gathered into a pending mask, served as inc_clk then ref_clk after settling.
module input_trigger_mc #(
  parameter int CHANNELS        = 6,
  parameter int DEBOUNCE_CYCLES = 10240,
  parameter int SETTLE_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input_trigger_mc_if.slave   bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INC     = 2'd1,
    S_SETTLE  = 2'd2,
    S_REFRESH = 2'd3
  } state_t;

  logic [CHANNELS-1:0] r_s1;
  logic [CHANNELS-1:0] r_s2;
  logic [CHANNELS-1:0] r_filt;
  logic [DB_W-1:0]     r_db_cnt [CHANNELS];
  logic [CHANNELS-1:0] r_pending;
  logic [ST_W-1:0]     r_st_cnt;
  state_t              r_state;
  logic                r_inc_clk;
  logic [CHANNELS-1:0] r_inc_mask;
  logic                r_ref_clk;
  logic                r_busy;
  logic                r_overrun;

  logic [CHANNELS-1:0] w_toggle;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_event;
  logic [CHANNELS-1:0] w_capture;
  logic                w_start;
  logic                w_ovr_set;

  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_toggle[i] = (r_s2[i] != r_filt[i]) && (r_db_cnt[i] == DB_LAST);
    end
  end

  assign w_rise = w_toggle & r_s2;
  assign w_fall = w_toggle & ~r_s2;

  always_comb begin
    w_event = '0;
    if (bus.enable) begin
      case (bus.edge_mode)
        2'b00:   w_event = w_rise;
        2'b01:   w_event = w_fall;
        2'b10:   w_event = w_toggle;
        default: w_event = '0;
      endcase
    end
  end

  // A round starts when IDLE sees pending work; those bits move to inc_mask on this edge,
  // so a fresh event on a captured channel is not an overrun.
  assign w_start   = (r_state == S_IDLE) && (r_pending != '0);
  assign w_capture = w_start ? r_pending : '0;
  assign w_ovr_set = |(w_event & r_pending & ~w_capture);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_filt <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= bus.trigger;
      r_s2 <= r_s1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (r_s2[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_toggle[i]) begin
          r_filt[i]   <= r_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_st_cnt   <= '0;
      r_inc_clk  <= 1'b0;
      r_inc_mask <= '0;
      r_ref_clk  <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_pending <= w_start ? w_event : (r_pending | w_event);

      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_inc_clk  <= 1'b1;
            r_inc_mask <= r_pending;
            r_busy     <= 1'b1;
            r_state    <= S_INC;
          end
        end
        S_INC: begin
          r_inc_clk  <= 1'b0;
          r_inc_mask <= '0;
          r_st_cnt   <= '0;
          r_state    <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_st_cnt == ST_LAST) begin
            r_ref_clk <= 1'b1;
            r_state   <= S_REFRESH;
          end else begin
            r_st_cnt <= r_st_cnt + ST_W'(1);
          end
        end
        S_REFRESH: begin
          r_ref_clk <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.inc_clk     = r_inc_clk;
  assign bus.inc_mask    = r_inc_mask;
  assign bus.ref_clk     = r_ref_clk;
  assign bus.busy        = r_busy;
  assign bus.overrun     = r_overrun;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_pending = r_pending;
endmodule

// File: tb/tb_input_trigger_mc.sv
// Directed bench for input_trigger_mc: main instance with 16-cycle debounce / 4-cycle settle,
// plus a long-settle instance so two events on one channel can land inside a single round.
module tb_input_trigger_mc;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   n_overlap;

  input_trigger_mc_if #(.CHANNELS(6)) bus();
  input_trigger_mc_if #(.CHANNELS(6)) bus2();

  input_trigger_mc #(.CHANNELS(6), .DEBOUNCE_CYCLES(16), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  input_trigger_mc #(.CHANNELS(6), .DEBOUNCE_CYCLES(16), .SETTLE_CYCLES(40)) dut_long (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.inc_clk && bus.ref_clk) n_overlap++;
    if (bus2.inc_clk && bus2.ref_clk) n_overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({bus.inc_clk, bus.inc_mask, bus.ref_clk, bus.busy, bus.overrun} !== 10'd0)
      $display("FAIL reset_outputs: got %b expected 0",
               {bus.inc_clk, bus.inc_mask, bus.ref_clk, bus.busy, bus.overrun});
    else n_pass++;
    n_checks++;
    if ({bus.dbg_state, bus.dbg_pending} !== 8'd0)
      $display("FAIL reset_state: got %h expected 0", {bus.dbg_state, bus.dbg_pending});
    else n_pass++;
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_clean_rise();
    bus.trigger[0] = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      tick();
      if (n == 18) begin
        n_checks++;
        if ({bus.inc_clk, bus.busy} !== 2'b00)
          $display("FAIL rise_before_inc: got %b expected 00", {bus.inc_clk, bus.busy});
        else n_pass++;
      end
      if (n == 19) begin
        n_checks++;
        if ({bus.inc_clk, bus.inc_mask, bus.busy} !== {1'b1, 6'b000001, 1'b1})
          $display("FAIL rise_inc: got %b expected 10000011", {bus.inc_clk, bus.inc_mask, bus.busy});
        else n_pass++;
      end
      if (n == 20) begin
        n_checks++;
        if ({bus.inc_clk, bus.inc_mask} !== 7'd0)
          $display("FAIL rise_inc_end: got %b expected 0", {bus.inc_clk, bus.inc_mask});
        else n_pass++;
      end
      if (n == 23) begin
        n_checks++;
        if ({bus.ref_clk, bus.busy} !== 2'b01)
          $display("FAIL rise_before_ref: got %b expected 01", {bus.ref_clk, bus.busy});
        else n_pass++;
      end
      if (n == 24) begin
        n_checks++;
        if ({bus.ref_clk, bus.busy} !== 2'b11)
          $display("FAIL rise_ref: got %b expected 11", {bus.ref_clk, bus.busy});
        else n_pass++;
      end
      if (n == 25) begin
        n_checks++;
        if ({bus.ref_clk, bus.busy, bus.overrun} !== 3'b000)
          $display("FAIL rise_idle: got %b expected 000", {bus.ref_clk, bus.busy, bus.overrun});
        else n_pass++;
      end
    end
  endtask

  task automatic test_bounce();
    int n_inc;
    int inc_at;
    logic [5:0] m;
    n_inc = 0; inc_at = 0; m = '0;
    for (int n = 0; n < 60; n++) begin
      if (n % 5 == 0) bus.trigger[2] = ~bus.trigger[2];
      tick();
      if (bus.inc_clk) begin n_inc++; m = bus.inc_mask; end
    end
    bus.trigger[2] = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (bus.inc_clk) begin
        n_inc++; m = bus.inc_mask;
        if (inc_at == 0) inc_at = n;
      end
    end
    n_checks++;
    if (n_inc !== 1) $display("FAIL bounce_count: got %0d expected 1", n_inc);
    else n_pass++;
    n_checks++;
    if (m !== 6'b000100) $display("FAIL bounce_mask: got %b expected 000100", m);
    else n_pass++;
    n_checks++;
    if (inc_at !== 19) $display("FAIL bounce_latency: got %0d expected 19", inc_at);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int n_inc;
    int n_ref;
    logic [5:0] m;
    n_inc = 0; n_ref = 0; m = '0;
    bus.trigger[1] = 1'b1;
    bus.trigger[4] = 1'b1;
    for (int n = 1; n <= 35; n++) begin
      tick();
      if (bus.inc_clk) begin n_inc++; m = bus.inc_mask; end
      if (bus.ref_clk) n_ref++;
    end
    n_checks++;
    if ({n_inc, n_ref} !== {32'd1, 32'd1})
      $display("FAIL simul_pulses: got inc=%0d ref=%0d expected 1/1", n_inc, n_ref);
    else n_pass++;
    n_checks++;
    if (m !== 6'b010010) $display("FAIL simul_mask: got %b expected 010010", m);
    else n_pass++;
  endtask

  task automatic test_settle_event();
    int inc_t[$];
    int ref_t[$];
    logic [5:0] masks[$];
    int n_inc;
    n_inc = 0;
    bus.trigger[0] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.inc_clk) n_inc++;
    end
    n_checks++;
    if (n_inc !== 0) $display("FAIL settle_fall_ignored: got %0d expected 0", n_inc);
    else n_pass++;
    bus.trigger[0] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus.inc_clk) begin inc_t.push_back(n); masks.push_back(bus.inc_mask); end
      if (bus.ref_clk) ref_t.push_back(n);
      if (n == 3) bus.trigger[3] = 1'b1;
    end
    n_checks++;
    if (inc_t.size() != 2 || ref_t.size() != 2)
      $display("FAIL settle_rounds: got inc=%0d ref=%0d expected 2/2", inc_t.size(), ref_t.size());
    else begin
      n_pass++;
      n_checks++;
      if ({inc_t[0], ref_t[0], masks[0]} !== {32'd19, 32'd24, 6'b000001})
        $display("FAIL settle_round1: got inc@%0d ref@%0d mask=%b expected 19/24/000001",
                 inc_t[0], ref_t[0], masks[0]);
      else n_pass++;
      n_checks++;
      if ({inc_t[1], ref_t[1], masks[1]} !== {32'd26, 32'd31, 6'b001000})
        $display("FAIL settle_round2: got inc@%0d ref@%0d mask=%b expected 26/31/001000",
                 inc_t[1], ref_t[1], masks[1]);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    bus2.trigger[0] = 1'b1;
    for (int n = 1; n <= 110; n++) begin
      tick();
      if (n == 20) bus2.trigger[3] = 1'b1;
      if (n == 40) bus2.trigger[3] = 1'b0;
      if (n == 19) begin
        n_checks++;
        if ({bus2.inc_clk, bus2.inc_mask} !== {1'b1, 6'b000001})
          $display("FAIL ovr_round1: got %b expected 1000001", {bus2.inc_clk, bus2.inc_mask});
        else n_pass++;
      end
      if (n == 57) begin
        n_checks++;
        if (bus2.overrun !== 1'b0) $display("FAIL ovr_early: got %b expected 0", bus2.overrun);
        else n_pass++;
      end
      if (n == 58) begin
        n_checks++;
        if (bus2.overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", bus2.overrun);
        else n_pass++;
      end
      if (n == 62) begin
        n_checks++;
        if ({bus2.inc_clk, bus2.inc_mask} !== {1'b1, 6'b001000})
          $display("FAIL ovr_round2: got %b expected 1001000", {bus2.inc_clk, bus2.inc_mask});
        else n_pass++;
      end
    end
    n_checks++;
    if ({bus2.overrun, bus2.busy} !== 2'b10)
      $display("FAIL ovr_sticky: got %b expected 10", {bus2.overrun, bus2.busy});
    else n_pass++;
    bus2.overrun_clr = 1'b1;
    tick();
    bus2.overrun_clr = 1'b0;
    tick();
    n_checks++;
    if (bus2.overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", bus2.overrun);
    else n_pass++;
  endtask

  task automatic test_edge_modes();
    int n_pulse;
    int inc_at;
    logic [5:0] m;
    bus.edge_mode = 2'b01;
    bus.trigger[5] = 1'b1;
    n_pulse = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus.inc_clk || bus.ref_clk) n_pulse++;
    end
    n_checks++;
    if (n_pulse !== 0) $display("FAIL fall_mode_rise: got %0d pulses expected 0", n_pulse);
    else n_pass++;
    bus.trigger[5] = 1'b0;
    inc_at = 0; m = '0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (bus.inc_clk && inc_at == 0) begin inc_at = n; m = bus.inc_mask; end
    end
    n_checks++;
    if ({inc_at, m} !== {32'd19, 6'b100000})
      $display("FAIL fall_mode_fall: got inc@%0d mask=%b expected 19/100000", inc_at, m);
    else n_pass++;
    bus.edge_mode = 2'b11;
    bus.trigger[5] = 1'b1;
    n_pulse = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus.inc_clk || bus.ref_clk) n_pulse++;
    end
    n_checks++;
    if (n_pulse !== 0) $display("FAIL none_mode: got %0d pulses expected 0", n_pulse);
    else n_pass++;
    bus.edge_mode = 2'b10;
    bus.enable = 1'b0;
    bus.trigger[5] = 1'b0;
    n_pulse = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus.inc_clk || bus.ref_clk) n_pulse++;
    end
    n_checks++;
    if ({n_pulse, bus.dbg_pending} !== {32'd0, 6'd0})
      $display("FAIL disabled: got %0d pulses pending=%b expected 0", n_pulse, bus.dbg_pending);
    else n_pass++;
    bus.enable = 1'b1;
    bus.edge_mode = 2'b00;
  endtask

  task automatic test_reset_midround();
    int n_early;
    int inc_at;
    logic [5:0] m;
    bus.trigger[5] = 1'b1;
    for (int n = 1; n <= 21; n++) begin
      tick();
      if (n == 19) begin
        n_checks++;
        if ({bus.inc_clk, bus.inc_mask} !== {1'b1, 6'b100000})
          $display("FAIL mid_inc: got %b expected 1100000", {bus.inc_clk, bus.inc_mask});
        else n_pass++;
      end
    end
    n_checks++;
    if (bus.dbg_state !== 2'd2) $display("FAIL mid_in_settle: got %0d expected 2", bus.dbg_state);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.inc_clk, bus.inc_mask, bus.ref_clk, bus.busy, bus.overrun, bus.dbg_state, bus.dbg_pending} !== 18'd0)
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {bus.inc_clk, bus.inc_mask, bus.ref_clk, bus.busy, bus.overrun, bus.dbg_state, bus.dbg_pending});
    else n_pass++;
    @(negedge clk);
    tick();
    reset = 1'b0;
    n_early = 0; inc_at = 0; m = '0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n < 19 && (bus.inc_clk || bus.ref_clk)) n_early++;
      if (bus.inc_clk && inc_at == 0) begin inc_at = n; m = bus.inc_mask; end
    end
    n_checks++;
    if (n_early !== 0) $display("FAIL mid_no_early_pulse: got %0d expected 0", n_early);
    else n_pass++;
    n_checks++;
    if ({inc_at, m} !== {32'd19, 6'b111111})
      $display("FAIL mid_redebounce: got inc@%0d mask=%b expected 19/111111", inc_at, m);
    else n_pass++;
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (n_overlap !== 0) $display("FAIL inc_ref_overlap: got %0d expected 0", n_overlap);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_overlap = 0;
    reset = 1'b1;
    bus.trigger = '0;  bus.edge_mode = 2'b00;  bus.enable = 1'b1;  bus.overrun_clr = 1'b0;
    bus2.trigger = '0; bus2.edge_mode = 2'b10; bus2.enable = 1'b1; bus2.overrun_clr = 1'b0;
    test_reset();
    test_clean_rise();
    test_bounce();
    test_simultaneous();
    test_settle_event();
    test_overrun();
    test_edge_modes();
    test_reset_midround();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
